// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its fetch queue.
package inst_fetch_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] PC_INC          = 32'd4;
    localparam int          ROM_WORDS_DEF   = 64;
    localparam int          FETCH_ENTRY_W   = 64;  // {pc, inst}

endpackage

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// Two-entry FIFO of {pc, inst} fetch entries with flush; head reads as zero when empty.
module fetch_queue
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  logic                     deq,
    input  logic                     flush,
    input  logic [FETCH_ENTRY_W-1:0] wdata,
    output logic [1:0]               count,
    output logic [FETCH_ENTRY_W-1:0] head
);

    logic [1:0]               count_q, count_d;
    logic                     wr_q, wr_d;
    logic                     rd_q, rd_d;
    logic [FETCH_ENTRY_W-1:0] mem_q [2];
    logic                     deq_ok;
    logic                     enq_ok;

    assign deq_ok = deq && (count_q != 2'd0);
    assign enq_ok = enq && ((count_q != 2'd2) || deq_ok) && !flush;

    always_comb begin
        count_d = count_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (flush) begin
            count_d = 2'd0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
        end else begin
            if (enq_ok) wr_d = ~wr_q;
            if (deq_ok) rd_d = ~rd_q;
            case ({enq_ok, deq_ok})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // NOTE: storage is deliberately not reset; the head is gated by count, so stale data never escapes.
    always_ff @(posedge clk) begin
        if (enq_ok) mem_q[wr_q] <= wdata;
    end

    assign count = count_q;
    assign head  = (count_q != 2'd0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// PC sequencing, range/alignment fault FSM and redirect handling in front of the fetch queue.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = ROM_WORDS_DEF,
    parameter int          QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_fault
);

    localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS * 4);
    localparam logic [1:0]  FULL_CNT  = 2'(QDEPTH);

    logic [31:0]              pc_q, pc_d;
    fetch_state_e             state_q, state_d;
    logic                     enq, flush, deq;
    logic [1:0]               q_count;
    logic [FETCH_ENTRY_W-1:0] q_head;
    logic                     redirect_bad;

    assign deq          = if_valid && id_ready;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= ROM_LIMIT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        enq     = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            state_d = redirect_bad ? FAULT : RUN;
        end else if (state_q == RUN) begin
            if (pc_q >= ROM_LIMIT) begin
                state_d = FAULT;
            end else if ((q_count != FULL_CNT) || deq) begin
                enq  = 1'b1;
                pc_d = pc_q + PC_INC;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .deq   (deq),
        .flush (flush),
        .wdata ({pc_q, rom_inst}),
        .count (q_count),
        .head  (q_head)
    );

    assign rom_a       = pc_q;
    assign if_valid    = (q_count != 2'd0);
    assign if_pc       = q_head[63:32];
    assign if_inst     = q_head[31:0];
    assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_a;
    logic [31:0] rom_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready = 1'b1;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom [64];

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rom_a          (rom_a),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    assign rom_inst = rom[rom_a[7:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain list of fetched {pc, inst} entries, a PC and a fault flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mfault;

    always @(posedge clk or posedge rst) begin
        int n;
        bit taken;
        if (rst) begin
            mq.delete();
            mpc    = 32'h0;
            mfault = 1'b0;
        end else begin
            n     = mq.size();
            taken = (n != 0) && id_ready;
            if (redirect_valid) begin
                mq.delete();
                mpc    = redirect_pc;
                mfault = (redirect_pc % 4 != 0) || (redirect_pc >= 32'd256);
            end else begin
                if (taken) void'(mq.pop_front());
                if (!mfault) begin
                    if (mpc >= 32'd256) begin
                        mfault = 1'b1;
                    end else if (n < 2 || taken) begin
                        mq.push_back('{pc: mpc, inst: rom[mpc / 4]});
                        mpc = mpc + 32'd4;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
            check("model_pc",    if_pc,   (mq.size() != 0) ? mq[0].pc   : 32'h0);
            check("model_inst",  if_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
            check("model_fault", {31'd0, fetch_fault}, {31'd0, mfault});
            check("model_rom_a", rom_a, mpc);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst      = 1'b1;
        id_ready = ready;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic head_is(input string name, input logic [31:0] pc, input logic [31:0] inst);
        check({name, "_valid"}, {31'd0, if_valid}, 32'd1);
        check({name, "_pc"}, if_pc, pc);
        check({name, "_inst"}, if_inst, inst);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        rom[0] = 32'h0000_0000;
        rom[1] = 32'h0010_0443;
        rom[2] = 32'h0410_1025;

        // Reset state, then sustained fetch with id_ready high.
        #2;
        check("reset_valid", {31'd0, if_valid}, 32'd0);
        check("reset_fault", {31'd0, fetch_fault}, 32'd0);
        check("reset_rom_a", rom_a, 32'h0);
        do_reset(1'b1);
        cyc(); head_is("seq0", 32'h00, 32'h0000_0000);
        cyc(); head_is("seq1", 32'h04, 32'h0010_0443);
        cyc(); head_is("seq2", 32'h08, 32'h0410_1025);

        // Back-pressure: queue fills and holds, then drains without gap.
        do_reset(1'b0);
        repeat (4) cyc();
        head_is("hold", 32'h00, 32'h0000_0000);
        check("hold_rom_a", rom_a, 32'h08);
        id_ready = 1'b1;
        cyc(); head_is("drain1", 32'h04, 32'h0010_0443);
        cyc(); head_is("drain2", 32'h08, 32'h0410_1025);
        cyc(); head_is("drain3", 32'h0C, rom[3]);

        // Redirect while the queue holds 0x04 and 0x08.
        do_reset(1'b0);
        repeat (4) cyc();
        id_ready = 1'b1;
        cyc();
        head_is("pre_redir", 32'h04, 32'h0010_0443);
        id_ready = 1'b0;
        redirect(32'h20);
        check("redir_bubble", {31'd0, if_valid}, 32'd0);
        cyc(); head_is("redir_tgt", 32'h20, rom[8]);
        id_ready = 1'b1;

        // Run off the end of the ROM into FAULT, then recover.
        redirect(32'hF0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (if_valid && if_pc == 32'hFC) found = 1'b1;
        end
        check("reach_fc", {31'd0, found}, 32'd1);
        check("last_word", if_inst, rom[63]);
        cyc();
        check("oob_fault", {31'd0, fetch_fault}, 32'd1);
        check("oob_valid", {31'd0, if_valid}, 32'd0);
        repeat (3) cyc();
        check("oob_hold_pc", rom_a, 32'h100);
        redirect(32'h10);
        check("recover_fault", {31'd0, fetch_fault}, 32'd0);
        cyc(); head_is("recover", 32'h10, rom[4]);

        // Misaligned and out-of-range redirect targets.
        redirect(32'h06);
        check("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        repeat (2) cyc();
        check("misalign_noenq", {31'd0, if_valid}, 32'd0);
        redirect(32'h300);
        check("far_fault", {31'd0, fetch_fault}, 32'd1);
        check("far_rom_a", rom_a, 32'h300);

        // Asynchronous reset mid-cycle with a full queue.
        redirect(32'h00);
        id_ready = 1'b0;
        repeat (4) cyc();
        head_is("full_before_rst", 32'h00, 32'h0000_0000);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, if_valid}, 32'd0);
        check("arst_pc", if_pc, 32'h0);
        check("arst_inst", if_inst, 32'h0);
        check("arst_rom_a", rom_a, 32'h0);
        check("arst_fault", {31'd0, fetch_fault}, 32'd0);
        id_ready = 1'b1;
        cyc();
        rst = 1'b0;
        cyc(); head_is("restart0", 32'h00, 32'h0000_0000);
        cyc(); head_is("restart1", 32'h04, 32'h0010_0443);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences the combinational instruction ROM for the pipelined MIPS core.
- Owns the PC and drives the ROM byte address; the ROM decodes the word index from bits [7:2].
- Buffers fetched words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects from EX with a queue flush, and flags fetches outside the ROM or misaligned redirect targets.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- ROM_WORDS, 64, number of ROM words; legal byte addresses are 0 to ROM_WORDS*4-4.
- QDEPTH, 2, fetch queue depth (fixed at 2; the pointers are 1 bit).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_a  output  32  byte address to the ROM; always equals the current PC.
- rom_inst  input  32  ROM data, combinational from rom_a in the same cycle.
- redirect_valid  input  1  taken branch or jump from EX; single-cycle pulse.
- redirect_pc  input  32  redirect target byte address.
- if_valid  output  1  queue head holds a valid instruction.
- if_inst  output  32  instruction at the queue head.
- if_pc  output  32  PC of the instruction at the queue head.
- id_ready  input  1  decode accepts the head this cycle.
- fetch_fault  output  1  high while the controller is in state FAULT.

Behaviour:
- Reset (asynchronous, active-high) sets: pc=RESET_PC, queue count=0, read/write pointers=0, state=RUN, if_valid=0, if_inst=0, if_pc=0, fetch_fault=0.
- State RUN:
  - A fetch occurs when count<2, or when count==2 and dequeue is high.
  - On a fetch, {pc, rom_inst} is written at the write pointer and pc <= pc+4 (32-bit modulo wrap).
- Dequeue = if_valid & id_ready; the read pointer advances by one.
  - Simultaneous enqueue and dequeue leave count unchanged.
- Range check: if pc >= ROM_WORDS*4 in RUN, no enqueue occurs, pc holds, and the next state is FAULT.
  - Entries already queued keep draining normally.
- State FAULT:
  - No fetches; fetch_fault=1.
  - Exit only through a legal redirect or reset.
- Redirect (redirect_valid=1) has highest priority in any state:
  - Queue flushed in that cycle: count=0, pointers=0.
  - A dequeue handshake in the same cycle still counts as consumed by decode.
  - No enqueue in that cycle; pc <= redirect_pc.
  - if redirect_pc[1:0]!=0 or redirect_pc >= ROM_WORDS*4, next state is FAULT; otherwise next state is RUN.
- Latency:
  - First instruction is visible one cycle after the rst falling edge (if_valid rises after the first rising clk edge).
  - After a redirect at edge N, the target instruction is visible after edge N+1 (one bubble).
- Outputs:
  - if_valid = (count!=0).
  - if_inst and if_pc come from the head entry when count!=0, and are 0 when empty.
  - Outputs are combinational from registered state only; there is no combinational path from id_ready to outputs.
- Sustained throughput: one instruction per cycle with id_ready held high.
- Full queue with id_ready=0: pc and queue hold and no ROM data is captured; if_inst/if_pc remain stable while if_valid=1 and not accepted.
- rst asserted mid-operation clears everything immediately, regardless of clk.

Decomposition:
- Shared package holds:
  - state encoding: RUN=1'b0, FAULT=1'b1;
  - PC increment constant 32'd4;
  - ROM_WORDS default;
  - the fetch-entry width constant (64 bits = pc + inst).
- One sub-module is natural: fetch_queue, a 2-entry synchronous FIFO with:
  - enqueue, dequeue and flush inputs;
  - simultaneous enqueue/dequeue when full;
  - count and head outputs.
- inst_fetch_ctrl itself contains the PC register, FSM, range/alignment checks, and the fetch/redirect priority logic.

Test Plan:
- Reset release, id_ready=1, ROM: word0=0x00000000, word1=0x00100443, word2=0x04101025 -> consecutive cycles show (if_pc, if_inst) = (0x00, 0x00000000), (0x04, 0x00100443), (0x08, 0x04101025); if_valid stays 1.
- id_ready=0 for 4 cycles after reset -> count reaches 2, pc=0x08, head stays (0x00, word0); id_ready=1 -> drains 0x00, then 0x04, then 0x08 with no gap or duplicate.
- Redirect to 0x20 while the queue holds 0x04 and 0x08 -> next cycle if_valid=0; following cycle if_pc=0x20 with if_inst=word8; 0x04 and 0x08 are never presented.
- Run sequentially to pc=0xFC -> word 0x3F is delivered; pc=0x100 raises fetch_fault the next cycle, if_valid falls once the queue drains; redirect to 0x10 clears the fault and 0x10 is delivered.
- Redirect to 0x06 (misaligned) -> fetch_fault=1 and no enqueue; redirect to 0x300 -> fault stays set.
- Assert rst asynchronously mid-stream with the queue full -> outputs clear without a clk edge; after release, fetch restarts at RESET_PC.
